// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with redirect and cancel tracking.
//
// Each rising edge of clk selects the next fetch address. The priority order
// is trap redirect, then branch redirect, then hold, then a sequential step of
// STEP bytes. An accepted redirect loads the aligned target and marks every
// fetch stage as stale. The stale marks then drain out one stage per
// advancing cycle.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   hold           stall; freezes pc/cancel/redirect_cnt unless a redirect is present
//   trap_valid     trap redirect request (wins over br_valid)
//   trap_pc        trap target (raw, may be misaligned)
//   br_valid       branch/jump redirect request
//   br_pc          branch target (raw, may be misaligned)
//   pc             current fetch address (registered)
//   cancel         bit i set = instruction in fetch stage i is stale (registered)
//   misalign       one-cycle pulse: accepted redirect target had low bits set
//   misalign_addr  raw offending target, captured with misalign
//   redirect_cnt   saturating count of accepted redirects
module pc_gen #(
  parameter int unsigned ADDR_W        = 32,
  parameter logic [31:0] RESET_ADDR    = 32'h8000_0000,
  parameter int unsigned STEP          = 4,
  parameter int unsigned ALIGN_BITS    = 2,
  parameter int unsigned CANCEL_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic                     trap_valid,
  input  logic [ADDR_W-1:0]        trap_pc,
  input  logic                     br_valid,
  input  logic [ADDR_W-1:0]        br_pc,
  output logic [ADDR_W-1:0]        pc,
  output logic [CANCEL_STAGES-1:0] cancel,
  output logic                     misalign,
  output logic [ADDR_W-1:0]        misalign_addr,
  output logic [15:0]              redirect_cnt
);

  // Mask of the low bits that must be zero; all-zero when ALIGN_BITS=0, which
  // disables truncation and makes the misalign check constant false.
  localparam logic [ADDR_W-1:0] LOW_MASK = ~({ADDR_W{1'b1}} << ALIGN_BITS);
  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(STEP);

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return a & ~LOW_MASK;
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
    return |(a & LOW_MASK);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Stage 0: redirect selection (combinational, trap wins over branch)
  logic              redir_vld_p0;
  logic [ADDR_W-1:0] tgt_p0;

  always_comb begin
    redir_vld_p0 = trap_valid | br_valid;
    tgt_p0       = trap_valid ? trap_pc : br_pc;
  end

  // Stage 1: registered fetch state
  logic [ADDR_W-1:0]        pc_p1;
  logic [CANCEL_STAGES-1:0] cancel_p1;
  logic                     misalign_p1;
  logic [ADDR_W-1:0]        maddr_p1;
  logic [15:0]              cnt_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1       <= RESET_PC;
      cancel_p1   <= '0;
      misalign_p1 <= 1'b0;
      maddr_p1    <= '0;
      cnt_p1      <= '0;
    end else if (redir_vld_p0) begin
      pc_p1       <= align_addr(tgt_p0);
      cancel_p1   <= '1;
      misalign_p1 <= is_misaligned(tgt_p0);
      if (is_misaligned(tgt_p0)) begin
        maddr_p1 <= tgt_p0;
      end
      cnt_p1      <= sat_inc(cnt_p1);
    end else begin
      // misalign is a pulse: it drops on any cycle without a redirect,
      // including held cycles.
      misalign_p1 <= 1'b0;
      if (!hold) begin
        pc_p1     <= pc_p1 + STEP_A;
        cancel_p1 <= cancel_p1 << 1;
      end
    end
  end

  assign pc            = pc_p1;
  assign cancel        = cancel_p1;
  assign misalign      = misalign_p1;
  assign misalign_addr = maddr_p1;
  assign redirect_cnt  = cnt_p1;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: a table of vectors against a default build,
// plus a hand-written sequence against an 8-bit, ALIGN_BITS=0 build.
module tb_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build
  logic        rst, hold, trap_valid, br_valid;
  logic [31:0] trap_pc, br_pc, pc, misalign_addr;
  logic [1:0]  cancel;
  logic        misalign;
  logic [15:0] redirect_cnt;

  pc_gen dut (
    .clk(clk), .rst(rst), .hold(hold),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .br_valid(br_valid), .br_pc(br_pc),
    .pc(pc), .cancel(cancel), .misalign(misalign),
    .misalign_addr(misalign_addr), .redirect_cnt(redirect_cnt)
  );

  // 8-bit build: wraparound, no alignment, single cancel stage
  logic       rst8, hold8, trap_valid8, br_valid8;
  logic [7:0] trap_pc8, br_pc8, pc8, misalign_addr8;
  logic [0:0] cancel8;
  logic       misalign8;
  logic [15:0] redirect_cnt8;

  pc_gen #(
    .ADDR_W(8), .RESET_ADDR(32'h0000_00F8), .STEP(4),
    .ALIGN_BITS(0), .CANCEL_STAGES(1)
  ) dut8 (
    .clk(clk), .rst(rst8), .hold(hold8),
    .trap_valid(trap_valid8), .trap_pc(trap_pc8),
    .br_valid(br_valid8), .br_pc(br_pc8),
    .pc(pc8), .cancel(cancel8), .misalign(misalign8),
    .misalign_addr(misalign_addr8), .redirect_cnt(redirect_cnt8)
  );

  typedef struct {
    logic        rst;
    logic        hold;
    logic        tv;
    logic [31:0] tpc;
    logic        bv;
    logic [31:0] bpc;
    logic [31:0] e_pc;
    logic [1:0]  e_cancel;
    logic        e_mis;
    logic [31:0] e_maddr;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic h,
                              input logic tv, input logic [31:0] tpc,
                              input logic bv, input logic [31:0] bpc,
                              input logic [31:0] e_pc, input logic [1:0] e_cancel,
                              input logic e_mis, input logic [31:0] e_maddr,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.rst = r; v.hold = h; v.tv = tv; v.tpc = tpc; v.bv = bv; v.bpc = bpc;
    v.e_pc = e_pc; v.e_cancel = e_cancel; v.e_mis = e_mis;
    v.e_maddr = e_maddr; v.e_cnt = e_cnt;
    return v;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    //                rst  hold tv  tpc           bv  bpc           pc            cnc    mis  maddr         cnt
    vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h8000_0000,2'b00,1'b0,32'h0,        16'd0);
    vecs[1]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h8000_0004,2'b00,1'b0,32'h0,        16'd0);
    vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h8000_0008,2'b00,1'b0,32'h0,        16'd0);
    vecs[3]  = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h8000_0008,2'b00,1'b0,32'h0,        16'd0);
    vecs[4]  = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h8000_0008,2'b00,1'b0,32'h0,        16'd0);
    vecs[5]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h8000_000C,2'b00,1'b0,32'h0,        16'd0);
    vecs[6]  = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h0000_1000,32'h0000_1000,2'b11,1'b0,32'h0,        16'd1);
    vecs[7]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1004,2'b10,1'b0,32'h0,        16'd1);
    vecs[8]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1008,2'b00,1'b0,32'h0,        16'd1);
    vecs[9]  = mk(1'b0,1'b0,1'b1,32'h0000_0200,1'b1,32'h0000_1000,32'h0000_0200,2'b11,1'b0,32'h0,        16'd2);
    vecs[10] = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0200,2'b11,1'b0,32'h0,        16'd2);
    vecs[11] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0204,2'b10,1'b0,32'h0,        16'd2);
    vecs[12] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0000_1006,32'h0000_1004,2'b11,1'b1,32'h0000_1006,16'd3);
    vecs[13] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_1008,2'b10,1'b0,32'h0000_1006,16'd3);
    vecs[14] = mk(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0000_2000,32'h8000_0000,2'b00,1'b0,32'h0,        16'd0);
    vecs[15] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h8000_0004,2'b00,1'b0,32'h0,        16'd0);
    vecs[16] = mk(1'b0,1'b0,1'b1,32'h0000_0203,1'b0,32'h0,        32'h0000_0200,2'b11,1'b1,32'h0000_0203,16'd1);
    vecs[17] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h0000_1001,32'h0000_1000,2'b11,1'b1,32'h0000_1001,16'd2);
    vecs[18] = mk(1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0000_1002,32'h8000_0000,2'b00,1'b0,32'h0,        16'd0);

    rst = 1'b1; hold = 1'b0; trap_valid = 1'b0; trap_pc = '0; br_valid = 1'b0; br_pc = '0;
    rst8 = 1'b1; hold8 = 1'b0; trap_valid8 = 1'b0; trap_pc8 = '0; br_valid8 = 1'b0; br_pc8 = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; hold = vecs[i].hold;
      trap_valid = vecs[i].tv; trap_pc = vecs[i].tpc;
      br_valid = vecs[i].bv; br_pc = vecs[i].bpc;
      @(posedge clk);
      #1;
      n_vec++;
      chk("pc", i, pc, vecs[i].e_pc);
      chk("cancel", i, {30'd0, cancel}, {30'd0, vecs[i].e_cancel});
      chk("misalign", i, {31'd0, misalign}, {31'd0, vecs[i].e_mis});
      chk("misalign_addr", i, misalign_addr, vecs[i].e_maddr);
      chk("redirect_cnt", i, {16'd0, redirect_cnt}, {16'd0, vecs[i].e_cnt});
    end

    // 8-bit build: reset, wrap FC -> 00 silently, unaligned redirect taken as-is.
    @(negedge clk); rst8 = 1'b1;
    @(posedge clk); #1; n_vec++;
    chk("pc8_reset", 100, {24'd0, pc8}, 32'h0000_00F8);
    chk("cancel8_reset", 100, {31'd0, cancel8}, 32'd0);

    @(negedge clk); rst8 = 1'b0;
    @(posedge clk); #1; n_vec++;
    chk("pc8_step", 101, {24'd0, pc8}, 32'h0000_00FC);

    @(negedge clk);
    @(posedge clk); #1; n_vec++;
    chk("pc8_wrap", 102, {24'd0, pc8}, 32'h0000_0000);
    chk("misalign8_wrap", 102, {31'd0, misalign8}, 32'd0);

    @(negedge clk); br_valid8 = 1'b1; br_pc8 = 8'h13;
    @(posedge clk); #1; n_vec++;
    chk("pc8_noalign", 103, {24'd0, pc8}, 32'h0000_0013);
    chk("cancel8_redir", 103, {31'd0, cancel8}, 32'd1);
    chk("misalign8_off", 103, {31'd0, misalign8}, 32'd0);
    chk("maddr8_hold", 103, {24'd0, misalign_addr8}, 32'd0);
    chk("cnt8", 103, {16'd0, redirect_cnt8}, 32'd1);

    @(negedge clk); br_valid8 = 1'b0;
    @(posedge clk); #1; n_vec++;
    chk("pc8_after", 104, {24'd0, pc8}, 32'h0000_0017);
    chk("cancel8_drain", 104, {31'd0, cancel8}, 32'd0);

    // Hold with a redirect in flight: cancel must freeze, then drain.
    @(negedge clk); rst = 1'b0; hold = 1'b0; br_valid = 1'b1; br_pc = 32'h0000_4000;
    @(posedge clk); #1; n_vec++;
    chk("pc_redir2", 105, pc, 32'h0000_4000);
    @(negedge clk); br_valid = 1'b0;
    @(posedge clk); #1; n_vec++;
    chk("cancel_shift1", 106, {30'd0, cancel}, 32'd2);
    @(negedge clk); hold = 1'b1;
    @(posedge clk); #1; n_vec++;
    chk("cancel_held", 107, {30'd0, cancel}, 32'd2);
    chk("pc_held", 107, pc, 32'h0000_4004);
    @(negedge clk); hold = 1'b0;
    @(posedge clk); #1; n_vec++;
    chk("cancel_clear", 108, {30'd0, cancel}, 32'd0);
    chk("pc_release", 108, pc, 32'h0000_4008);
    chk("cnt_after", 108, {16'd0, redirect_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
